// File: rtl/uv_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uv_csr_pkg
// Purpose : Shared definitions for the machine-mode CSR file. Holds the CSR
//           address map, the mstatus / mie / mip bit positions, the mcause
//           field layout and a helper that packs mcause.
// Rev     : 1.0  initial release
// ============================================================================
package uv_csr_pkg;

    // CSR address map
    localparam logic [11:0] c_CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] c_CSR_MISA      = 12'h301;
    localparam logic [11:0] c_CSR_MIE       = 12'h304;
    localparam logic [11:0] c_CSR_MTVEC     = 12'h305;
    localparam logic [11:0] c_CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_CSR_MEPC      = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] c_CSR_MTVAL     = 12'h343;
    localparam logic [11:0] c_CSR_MIP       = 12'h344;
    localparam logic [11:0] c_CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_CSR_MHARTID   = 12'hF14;

    // mstatus fields
    localparam int unsigned c_MSTATUS_MIE    = 3;
    localparam int unsigned c_MSTATUS_MPIE   = 7;
    localparam int unsigned c_MSTATUS_MPP_LO = 11;
    localparam int unsigned c_MSTATUS_MPP_HI = 12;
    localparam logic [1:0]  c_MPP_MACHINE    = 2'b11;

    // mie / mip bit positions (software / timer / external)
    localparam int unsigned c_IRQ_SFT = 3;
    localparam int unsigned c_IRQ_TMR = 7;
    localparam int unsigned c_IRQ_EXT = 11;

    // mcause layout
    localparam int unsigned c_MCAUSE_INT    = 31;
    localparam int unsigned c_MCAUSE_CODE_W = 4;

    // mcause is {interrupt flag, zeros, cause code}
    function automatic logic [31:0] mcause_pack(
        input logic                       is_int,
        input logic [c_MCAUSE_CODE_W-1:0] code
    );
        logic [31:0] v;
        v                        = '0;
        v[c_MCAUSE_INT]          = is_int;
        v[c_MCAUSE_CODE_W-1:0]   = code;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uv_csr_cnt64.sv
`default_nettype none
// ============================================================================
// Module  : uv_csr_cnt64
// Purpose : 64-bit free-running counter with an increment enable and
//           independent write strobes for the low and high 32-bit halves.
//           A write to either half suppresses the increment of the whole
//           counter in that cycle. Carry into the high half is immediate.
// Ports   : clk, rst_n   - clock, async active-low reset
//           i_inc        - count enable
//           i_wr_lo/hi   - replace low / high half with i_wdata
//           i_wdata      - write data
//           o_cnt        - current counter value
// Rev     : 1.0  initial release
// ============================================================================
module uv_csr_cnt64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_cnt
);

    logic [63:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) r_cnt[31:0]  <= i_wdata;
            if (i_wr_hi) r_cnt[63:32] <= i_wdata;
        end else if (i_inc) begin
            // Natural 64-bit wrap from all-ones to zero.
            r_cnt <= r_cnt + 64'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/uv_csr_trap.sv
`default_nettype none
// ============================================================================
// Module  : uv_csr_trap
// Purpose : Machine-mode CSR file. Consumes the commit stage's CSR write-back,
//           retire pulse and trap entry/exit, maintains the trap CSRs and the
//           mcycle/minstret counters, and returns mepc/mtvec/MIE/mie to the
//           commit stage. Provides a combinational read port to the decoder.
// Ports   : clk, rst_n                 - clock, async active-low reset
//           rd_idx/rd_data/rd_ill      - decoder read port
//           cm2cs_csr_*                - CSR write-back
//           cm2cs_instret              - retire pulse
//           cm2cs_trap_*               - trap entry / mret and trap payload
//           irq_ext/sft/tmr            - raw interrupt lines
//           cs2cm_*                    - status returned to commit
// Rev     : 1.0  initial release
// ============================================================================
module uv_csr_trap
    import uv_csr_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [XLEN-1:0] HART_ID   = 32'h0000_0000,
    parameter logic [XLEN-1:0] MISA_VAL  = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     rd_idx,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_ill,
    input  logic            cm2cs_csr_vld,
    input  logic [11:0]     cm2cs_csr_idx,
    input  logic [XLEN-1:0] cm2cs_csr_data,
    input  logic            cm2cs_instret,
    input  logic            cm2cs_trap_trig,
    input  logic            cm2cs_trap_exit,
    input  logic            cm2cs_trap_type,
    input  logic [3:0]      cm2cs_trap_code,
    input  logic [XLEN-1:0] cm2cs_trap_mepc,
    input  logic [XLEN-1:0] cm2cs_trap_info,
    input  logic            irq_ext,
    input  logic            irq_sft,
    input  logic            irq_tmr,
    output logic [XLEN-1:0] cs2cm_mepc,
    output logic [XLEN-1:0] cs2cm_mtvec,
    output logic            cs2cm_mstatus_mie,
    output logic            cs2cm_mie_meie,
    output logic            cs2cm_mie_msie,
    output logic            cs2cm_mie_mtie
);

    // mtvec bit 1 is always zero; reserved modes collapse onto the legal ones.
    localparam logic [31:0] c_MTVEC_RST_LEGAL = {MTVEC_RST[31:2], 1'b0, MTVEC_RST[0]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_msie;
    logic        r_mie_mtie;
    logic        r_mie_meie;
    logic        r_mip_msip;
    logic        r_mip_mtip;
    logic        r_mip_meip;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic        r_mcause_int;
    logic [3:0]  r_mcause_code;
    logic [31:0] r_mtval;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;

    // ------------------------------------------------------------------
    // Write decode. A trap entry or exit owns the trap CSRs for the cycle,
    // so a coincident write-back to them is dropped.
    // ------------------------------------------------------------------
    logic w_trap_evt;
    logic w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch;
    logic w_wr_mepc, w_wr_mcause, w_wr_mtval;
    logic w_wr_mcycle, w_wr_mcycleh, w_wr_minstret, w_wr_minstreth;

    assign w_trap_evt     = cm2cs_trap_trig || cm2cs_trap_exit;

    assign w_wr_mstatus   = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MSTATUS) && !w_trap_evt;
    assign w_wr_mepc      = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MEPC)    && !w_trap_evt;
    assign w_wr_mcause    = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MCAUSE)  && !w_trap_evt;
    assign w_wr_mtval     = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MTVAL)   && !w_trap_evt;
    assign w_wr_mie       = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MIE);
    assign w_wr_mtvec     = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MTVEC);
    assign w_wr_mscratch  = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MSCRATCH);
    assign w_wr_mcycle    = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MCYCLE);
    assign w_wr_mcycleh   = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MCYCLEH);
    assign w_wr_minstret  = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MINSTRET);
    assign w_wr_minstreth = cm2cs_csr_vld && (cm2cs_csr_idx == c_CSR_MINSTRETH);

    // ------------------------------------------------------------------
    // mstatus: trap entry beats mret, both beat a CSR write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (cm2cs_trap_trig) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (cm2cs_trap_exit) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
            r_mstatus_mie  <= cm2cs_csr_data[c_MSTATUS_MIE];
            r_mstatus_mpie <= cm2cs_csr_data[c_MSTATUS_MPIE];
        end
    end

    // ------------------------------------------------------------------
    // Trap payload registers: mepc / mcause / mtval
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mepc        <= '0;
            r_mcause_int  <= 1'b0;
            r_mcause_code <= '0;
            r_mtval       <= '0;
        end else if (cm2cs_trap_trig) begin
            r_mepc        <= cm2cs_trap_mepc & ~32'h3;
            r_mcause_int  <= cm2cs_trap_type;
            r_mcause_code <= cm2cs_trap_code;
            // Interrupts carry no faulting value.
            r_mtval       <= cm2cs_trap_type ? 32'h0 : cm2cs_trap_info;
        end else begin
            if (w_wr_mepc) begin
                r_mepc <= cm2cs_csr_data & ~32'h3;
            end
            if (w_wr_mcause) begin
                r_mcause_int  <= cm2cs_csr_data[c_MCAUSE_INT];
                r_mcause_code <= cm2cs_csr_data[c_MCAUSE_CODE_W-1:0];
            end
            if (w_wr_mtval) begin
                r_mtval <= cm2cs_csr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Plain writable CSRs and the interrupt-pending sampler
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie_msie <= 1'b0;
            r_mie_mtie <= 1'b0;
            r_mie_meie <= 1'b0;
            r_mtvec    <= c_MTVEC_RST_LEGAL;
            r_mscratch <= '0;
            r_mip_msip <= 1'b0;
            r_mip_mtip <= 1'b0;
            r_mip_meip <= 1'b0;
        end else begin
            if (w_wr_mie) begin
                r_mie_msie <= cm2cs_csr_data[c_IRQ_SFT];
                r_mie_mtie <= cm2cs_csr_data[c_IRQ_TMR];
                r_mie_meie <= cm2cs_csr_data[c_IRQ_EXT];
            end
            if (w_wr_mtvec) begin
                r_mtvec <= {cm2cs_csr_data[31:2], 1'b0, cm2cs_csr_data[0]};
            end
            if (w_wr_mscratch) begin
                r_mscratch <= cm2cs_csr_data;
            end
            r_mip_msip <= irq_sft;
            r_mip_mtip <= irq_tmr;
            r_mip_meip <= irq_ext;
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    uv_csr_cnt64 u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr_mcycle),
        .i_wr_hi (w_wr_mcycleh),
        .i_wdata (cm2cs_csr_data),
        .o_cnt   (w_mcycle)
    );

    uv_csr_cnt64 u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (cm2cs_instret),
        .i_wr_lo (w_wr_minstret),
        .i_wr_hi (w_wr_minstreth),
        .i_wdata (cm2cs_csr_data),
        .o_cnt   (w_minstret)
    );

    // ------------------------------------------------------------------
    // Combinational read port (shows the pre-update value)
    // ------------------------------------------------------------------
    logic [31:0] w_rd_data;
    logic        w_rd_ill;

    always_comb begin
        w_rd_data = '0;
        w_rd_ill  = 1'b0;
        case (rd_idx)
            c_CSR_MSTATUS: begin
                w_rd_data[c_MSTATUS_MIE]                     = r_mstatus_mie;
                w_rd_data[c_MSTATUS_MPIE]                    = r_mstatus_mpie;
                w_rd_data[c_MSTATUS_MPP_HI:c_MSTATUS_MPP_LO] = c_MPP_MACHINE;
            end
            c_CSR_MISA:      w_rd_data = MISA_VAL;
            c_CSR_MIE: begin
                w_rd_data[c_IRQ_SFT] = r_mie_msie;
                w_rd_data[c_IRQ_TMR] = r_mie_mtie;
                w_rd_data[c_IRQ_EXT] = r_mie_meie;
            end
            c_CSR_MTVEC:     w_rd_data = r_mtvec;
            c_CSR_MSCRATCH:  w_rd_data = r_mscratch;
            c_CSR_MEPC:      w_rd_data = r_mepc;
            c_CSR_MCAUSE:    w_rd_data = mcause_pack(r_mcause_int, r_mcause_code);
            c_CSR_MTVAL:     w_rd_data = r_mtval;
            c_CSR_MIP: begin
                w_rd_data[c_IRQ_SFT] = r_mip_msip;
                w_rd_data[c_IRQ_TMR] = r_mip_mtip;
                w_rd_data[c_IRQ_EXT] = r_mip_meip;
            end
            c_CSR_MCYCLE:    w_rd_data = w_mcycle[31:0];
            c_CSR_MCYCLEH:   w_rd_data = w_mcycle[63:32];
            c_CSR_MINSTRET:  w_rd_data = w_minstret[31:0];
            c_CSR_MINSTRETH: w_rd_data = w_minstret[63:32];
            c_CSR_MHARTID:   w_rd_data = HART_ID;
            default:         w_rd_ill  = 1'b1;
        endcase
    end

    assign rd_data           = w_rd_data;
    assign rd_ill            = w_rd_ill;

    assign cs2cm_mepc        = r_mepc;
    assign cs2cm_mtvec       = r_mtvec;
    assign cs2cm_mstatus_mie = r_mstatus_mie;
    assign cs2cm_mie_meie    = r_mie_meie;
    assign cs2cm_mie_msie    = r_mie_msie;
    assign cs2cm_mie_mtie    = r_mie_mtie;

endmodule
`default_nettype wire
